// File: rtl/sprite_anim_layer.sv
// Sprite layer with run/jump/duck/dead poses and a frame-synchronous run animation.
// Geometry and pose are captured once per frame so a sprite never tears mid-scan;
// pixel and in-box outputs are registered one cycle after the beam position.
module sprite_anim_layer #(
    parameter int unsigned HPOS_W   = 9,
    parameter int unsigned VPOS_W   = 9,
    parameter int unsigned SPR_W    = 16,
    parameter int unsigned SPR_H    = 16,
    parameter int unsigned X_POS    = 32,
    parameter int unsigned ANIM_DIV = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [HPOS_W-1:0] i_hpos,
    input  logic [VPOS_W-1:0] i_vpos,
    input  logic              i_frame_start,
    input  logic [VPOS_W-1:0] i_sprite_vpos,
    input  logic [1:0]        i_pose,
    input  logic              i_anim_en,
    output logic              o_color,
    output logic              o_in_box
);

    // Row/column index widths; bitmaps are padded to power-of-two geometry so every
    // index is exact-width and out-of-sprite slots simply read as blank.
    localparam int unsigned ROW_W    = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int unsigned COL_W    = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int unsigned ROWS     = 1 << ROW_W;
    localparam int unsigned COLS     = 1 << COL_W;
    localparam int unsigned BMP_BITS = ROWS * COLS;
    localparam int unsigned IMG_BITS = 5 * BMP_BITS;
    localparam int unsigned IMG_AW   = $clog2(IMG_BITS);
    localparam int unsigned CNT_W    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    typedef enum logic [1:0] {
        PoseRun  = 2'd0,
        PoseJump = 2'd1,
        PoseDuck = 2'd2,
        PoseDead = 2'd3
    } pose_e;

    // 16x16 master art: RUN0, RUN1, JUMP, DUCK, DEAD. Row 0 is top, bit 15 is leftmost.
    localparam logic [15:0] ART [80] = '{
        16'h0000, 16'h03F8, 16'h07FC, 16'h06FC, 16'h87FC, 16'h87E0, 16'h87F8, 16'hC7C0,
        16'hEFC0, 16'hFFC0, 16'h7FC0, 16'h3F80, 16'h1F00, 16'h1980, 16'h1000, 16'h1800,
        16'h0000, 16'h03F8, 16'h07FC, 16'h06FC, 16'h87FC, 16'h87E0, 16'h87F8, 16'hC7C0,
        16'hEFC0, 16'hFFC0, 16'h7FC0, 16'h3F80, 16'h1F00, 16'h0D80, 16'h0C80, 16'h0081,
        16'h0000, 16'h03F8, 16'h07FC, 16'h06FC, 16'h87FC, 16'h87E0, 16'h87F8, 16'hC7C0,
        16'hEFC0, 16'hFFC0, 16'h7FC0, 16'h3F80, 16'h1F00, 16'h3300, 16'h6180, 16'h0000,
        16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h8000,
        16'hC3FE, 16'hFFFF, 16'hFF7F, 16'h7FFF, 16'h3FF0, 16'h1E00, 16'h1200, 16'h1B00,
        16'h0000, 16'h03F8, 16'h0554, 16'h06AC, 16'h87FC, 16'h87E0, 16'h87F8, 16'hC7C0,
        16'hEFC0, 16'hFFC0, 16'h7FC0, 16'h3F80, 16'h1F00, 16'h1B00, 16'h1100, 16'h1980
    };

    // Resample the master art to SPR_W x SPR_H at elaboration. Each bitmap is stored
    // as {row, col} addressed bits with column 0 (leftmost) at the lowest index.
    function automatic logic [IMG_BITS-1:0] build_rom();
        logic [IMG_BITS-1:0] img;
        img = '0;
        for (int unsigned b = 0; b < 5; b++) begin
            for (int unsigned r = 0; r < SPR_H; r++) begin
                for (int unsigned c = 0; c < SPR_W; c++) begin
                    img[IMG_AW'(b * BMP_BITS + r * COLS + c)] =
                        ART[7'(b * 16 + (r * 16) / SPR_H)][4'(15 - (c * 16) / SPR_W)];
                end
            end
        end
        return img;
    endfunction

    localparam logic [IMG_BITS-1:0] ROM = build_rom();

    localparam logic [HPOS_W:0] X_LO = (HPOS_W + 1)'(X_POS);
    localparam logic [HPOS_W:0] X_HI = (HPOS_W + 1)'(X_POS + SPR_W);

    logic [VPOS_W-1:0] vpos_q, vpos_d;
    pose_e             pose_q, pose_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              phase_q, phase_d;

    logic [HPOS_W:0]      hpos_x;
    logic [VPOS_W:0]      vpos_x, vtop, vbot;
    logic                 in_x, in_y, in_box;
    logic [ROW_W-1:0]     row_idx;
    logic [COL_W-1:0]     col_idx;
    logic [BMP_BITS-1:0]  bmp_word;
    logic                 pixel;

    // Box test in widened arithmetic so a sprite near the last row clips instead of wrapping.
    assign hpos_x = {1'b0, i_hpos};
    assign vpos_x = {1'b0, i_vpos};
    assign vtop   = {1'b0, vpos_q};
    assign vbot   = vtop + (VPOS_W + 1)'(SPR_H);
    assign in_x   = (hpos_x >= X_LO) && (hpos_x < X_HI);
    assign in_y   = (vpos_x >= vtop) && (vpos_x < vbot);
    assign in_box = in_x && in_y;

    // Indices are held at zero outside the box so the ROM is never addressed out of range.
    assign row_idx = in_box ? ROW_W'(vpos_x - vtop) : '0;
    assign col_idx = in_box ? COL_W'(hpos_x - X_LO) : '0;
    assign pixel   = in_box & bmp_word[{row_idx, col_idx}];

    // Bitmap select from the latched pose and run phase.
    always_comb begin
        bmp_word = ROM[0 +: BMP_BITS];
        unique case (pose_q)
            PoseRun:  bmp_word = phase_q ? ROM[BMP_BITS +: BMP_BITS] : ROM[0 +: BMP_BITS];
            PoseJump: bmp_word = ROM[2 * BMP_BITS +: BMP_BITS];
            PoseDuck: bmp_word = ROM[3 * BMP_BITS +: BMP_BITS];
            PoseDead: bmp_word = ROM[4 * BMP_BITS +: BMP_BITS];
            default:  bmp_word = ROM[0 +: BMP_BITS];
        endcase
    end

    // Frame-start capture of geometry/pose and run-animation stepping.
    always_comb begin
        vpos_d  = vpos_q;
        pose_d  = pose_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (i_frame_start) begin
            vpos_d = i_sprite_vpos;
            pose_d = pose_e'(i_pose);
            if (pose_d != PoseRun) begin
                cnt_d   = '0;
                phase_d = 1'b0;
            end else if (i_anim_en) begin
                if (cnt_q == CNT_W'(ANIM_DIV - 1)) begin
                    cnt_d   = '0;
                    phase_d = ~phase_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // State and registered pixel outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpos_q   <= '0;
            pose_q   <= PoseRun;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            o_color  <= 1'b0;
            o_in_box <= 1'b0;
        end else begin
            vpos_q   <= vpos_d;
            pose_q   <= pose_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            o_color  <= pixel;
            o_in_box <= in_box;
        end
    end

endmodule

// File: tb/tb_sprite_anim_layer.sv
// Bench for sprite_anim_layer: behavioural model plus directed pins and random frames.
module tb_sprite_anim_layer;

    localparam int HW = 9;
    localparam int VW = 9;
    localparam int SW = 16;
    localparam int SH = 16;
    localparam int XP = 32;
    localparam int AD = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [HW-1:0] hpos;
    logic [VW-1:0] vpos;
    logic          fs;
    logic [VW-1:0] spr_vpos;
    logic [1:0]    pose;
    logic          en;
    logic          color;
    logic          in_box;

    always #5 clk = ~clk;

    sprite_anim_layer #(
        .HPOS_W  (HW),
        .VPOS_W  (VW),
        .SPR_W   (SW),
        .SPR_H   (SH),
        .X_POS   (XP),
        .ANIM_DIV(AD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_hpos       (hpos),
        .i_vpos       (vpos),
        .i_frame_start(fs),
        .i_sprite_vpos(spr_vpos),
        .i_pose       (pose),
        .i_anim_en    (en),
        .o_color      (color),
        .o_in_box     (in_box)
    );

    // Reference bitmaps: RUN0, RUN1, JUMP, DUCK, DEAD; bit 15 is the leftmost column.
    logic [15:0] art [5][16] = '{
        '{16'h0000, 16'h03F8, 16'h07FC, 16'h06FC, 16'h87FC, 16'h87E0, 16'h87F8, 16'hC7C0,
          16'hEFC0, 16'hFFC0, 16'h7FC0, 16'h3F80, 16'h1F00, 16'h1980, 16'h1000, 16'h1800},
        '{16'h0000, 16'h03F8, 16'h07FC, 16'h06FC, 16'h87FC, 16'h87E0, 16'h87F8, 16'hC7C0,
          16'hEFC0, 16'hFFC0, 16'h7FC0, 16'h3F80, 16'h1F00, 16'h0D80, 16'h0C80, 16'h0081},
        '{16'h0000, 16'h03F8, 16'h07FC, 16'h06FC, 16'h87FC, 16'h87E0, 16'h87F8, 16'hC7C0,
          16'hEFC0, 16'hFFC0, 16'h7FC0, 16'h3F80, 16'h1F00, 16'h3300, 16'h6180, 16'h0000},
        '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h8000,
          16'hC3FE, 16'hFFFF, 16'hFF7F, 16'h7FFF, 16'h3FF0, 16'h1E00, 16'h1200, 16'h1B00},
        '{16'h0000, 16'h03F8, 16'h0554, 16'h06AC, 16'h87FC, 16'h87E0, 16'h87F8, 16'hC7C0,
          16'hEFC0, 16'hFFC0, 16'h7FC0, 16'h3F80, 16'h1F00, 16'h1B00, 16'h1100, 16'h1980}
    };

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    // Model state: latched top row, pose, and count of enabled RUN frame steps since
    // the last reset or non-RUN frame; the run phase is derived from that count.
    int   m_vpos  = 0;
    int   m_pose  = 0;
    int   m_steps = 0;
    logic exp_in  = 1'b0;
    logic exp_col = 1'b0;

    function automatic void check(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, got, want, $time);
        end
    endfunction

    function automatic void model_pixel(input int h, input int v,
                                        output logic ein, output logic ecol);
        int bmp;
        ein  = (h >= XP) && (h < XP + SW) && (v >= m_vpos) && (v < m_vpos + SH);
        bmp  = (m_pose == 0) ? (m_steps / AD) % 2 : m_pose + 1;
        ecol = 1'b0;
        if (ein) ecol = art[bmp][v - m_vpos][15 - (h - XP)];
    endfunction

    // Expected outputs come from the pre-edge state; frame starts update the model after.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vpos  = 0;
            m_pose  = 0;
            m_steps = 0;
            exp_in  = 1'b0;
            exp_col = 1'b0;
        end else begin
            model_pixel(int'(hpos), int'(vpos), exp_in, exp_col);
            if (fs) begin
                m_vpos = int'(spr_vpos);
                m_pose = int'(pose);
                if (m_pose != 0) m_steps = 0;
                else if (en) m_steps++;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("model_in_box", in_box, exp_in);
            check("model_color", color, exp_col);
        end
    end

    task automatic drive(input int h, input int v, input bit f, input int sv, input int p,
                         input bit e);
        @(negedge clk);
        hpos     = HW'(h);
        vpos     = VW'(v);
        fs       = f;
        spr_vpos = VW'(sv);
        pose     = 2'(p);
        en       = e;
    endtask

    // Beam cycle with garbage on the latch inputs; only frame starts may capture them.
    task automatic junk(input int h, input int v);
        drive(h, v, 1'b0, int'($urandom_range(511)), int'($urandom_range(3)),
              1'($urandom_range(1)));
    endtask

    task automatic frame(input int sv, input int p, input bit e);
        drive(0, 0, 1'b1, sv, p, e);
    endtask

    task automatic pin(input string name, input int h, input int v, input bit ein,
                       input bit ecol);
        junk(h, v);
        @(posedge clk);
        #1;
        check({name, "_in"}, in_box, ein);
        check({name, "_col"}, color, ecol);
    endtask

    int cur_top;

    initial begin
        rst_n    = 1'b0;
        hpos     = '0;
        vpos     = '0;
        fs       = 1'b0;
        spr_vpos = '0;
        pose     = '0;
        en       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in", in_box, 1'b0);
        check("reset_col", color, 1'b0);
        @(negedge clk);
        rst_n    = 1'b1;
        check_en = 1'b1;

        // Reset: box at row 0 right after release, then async clear mid-line.
        pin("rst_release", XP, 0, 1'b1, 1'b0);
        pin("ink_row9", XP, 9, 1'b1, 1'b1);
        junk(XP, 9);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_in", in_box, 1'b0);
        check("async_rst_col", color, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        pin("post_rst", XP, 0, 1'b1, 1'b0);

        // Latch: box stays at rows 100..115 while the requested row wanders.
        frame(100, 0, 1'b1);
        pin("latch_top", XP, 100, 1'b1, 1'b0);
        pin("latch_above", XP, 99, 1'b0, 1'b0);
        pin("latch_bottom", XP + SW - 1, 115, 1'b1, 1'b0);
        pin("latch_below", XP, 116, 1'b0, 1'b0);
        pin("no_tear_50", XP, 50, 1'b0, 1'b0);

        // Horizontal boundaries on row 9 of RUN0.
        pin("x_left_out", XP - 1, 109, 1'b0, 1'b0);
        pin("x_left_in", XP, 109, 1'b1, 1'b1);
        pin("x_right_in", XP + SW - 1, 109, 1'b1, 1'b0);
        pin("x_right_out", XP + SW, 109, 1'b0, 1'b0);

        // Animation: leg pixel at row 13, column 3 is ink in RUN0 and blank in RUN1.
        frame(100, 1, 1'b1);
        repeat (5) frame(100, 0, 1'b1);
        pin("run_step5", XP + 3, 113, 1'b1, 1'b1);
        frame(100, 0, 1'b1);
        pin("run_step6", XP + 3, 113, 1'b1, 1'b0);
        frame(100, 0, 1'b0);
        pin("run_frozen", XP + 3, 113, 1'b1, 1'b0);
        repeat (5) frame(100, 0, 1'b1);
        pin("run_step11", XP + 3, 113, 1'b1, 1'b0);
        frame(100, 0, 1'b1);
        pin("run_step12", XP + 3, 113, 1'b1, 1'b1);
        repeat (6) frame(100, 0, 1'b1);
        pin("run_step18", XP + 3, 113, 1'b1, 1'b0);
        frame(100, 1, 1'b1);
        pin("jump_bitmap", XP + 1, 114, 1'b1, 1'b1);
        frame(100, 0, 1'b1);
        pin("run_cleared", XP + 3, 113, 1'b1, 1'b1);

        // Clip: top row 508 draws only rows 508..511.
        frame(508, 3, 1'b1);
        pin("clip_row0", XP, 0, 1'b0, 1'b0);
        pin("clip_row11", XP + 5, 11, 1'b0, 1'b0);
        pin("clip_row508", XP, 508, 1'b1, 1'b0);
        pin("clip_row511", XP + 5, 511, 1'b1, 1'b1);
        cur_top = 508;

        // Random frames; the frame start lands inside the previous sprite's box.
        for (int f = 0; f < 40; f++) begin
            int nt;
            int p;
            bit e;
            nt = ($urandom_range(3) == 0) ? 496 + int'($urandom_range(15))
                                          : int'($urandom_range(511));
            p  = int'($urandom_range(5));
            if (p > 3) p = 0;
            e  = ($urandom_range(7) != 0);
            drive(XP + int'($urandom_range(SW - 1)), (cur_top + int'($urandom_range(SH - 1))) % 512,
                  1'b1, nt, p, e);
            cur_top = nt;
            for (int r = -3; r < SH + 3; r++) begin
                for (int h = XP - 8; h <= XP + SW + 8; h++) begin
                    junk(h, (cur_top + r + 512) % 512);
                end
            end
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sprite_anim_layer.md
SPRITE_ANIM_LAYER -- requirements
Module: sprite_anim_layer

Interface
REQ-001 Parameter HPOS_W, default 9, width of horizontal beam position.
REQ-002 Parameter VPOS_W, default 9, width of vertical beam position and sprite top row.
REQ-003 Parameter SPR_W, default 16, sprite width in pixels (1..32).
REQ-004 Parameter SPR_H, default 16, sprite height in rows (1..32).
REQ-005 Parameter X_POS, default 32, fixed leftmost sprite column.
REQ-006 Parameter ANIM_DIV, default 6, video frames per run-animation step (>=1).
REQ-007 Port clk, input, 1, pixel clock; all state on its rising edge.
REQ-008 Port rst_n, input, 1, asynchronous active-low reset.
REQ-009 Port i_hpos, input, HPOS_W, current beam column.
REQ-010 Port i_vpos, input, VPOS_W, current beam row.
REQ-011 Port i_frame_start, input, 1, one-cycle pulse once per frame during vertical blanking.
REQ-012 Port i_sprite_vpos, input, VPOS_W, requested sprite top row.
REQ-013 Port i_pose, input, 2, requested pose: 0 RUN, 1 JUMP, 2 DUCK, 3 DEAD.
REQ-014 Port i_anim_en, input, 1, enables run-animation stepping.
REQ-015 Port o_color, output, 1, registered sprite pixel (1 = ink).
REQ-016 Port o_in_box, output, 1, registered flag: beam inside sprite bounding box.

Function
REQ-017 ROM SHALL hold 5 bitmaps of SPR_H rows x SPR_W bits: RUN0, RUN1, JUMP, DUCK, DEAD; row 0 is top, bit SPR_W-1 is leftmost column.
REQ-018 On an i_frame_start cycle the block SHALL latch i_sprite_vpos into vpos_q and i_pose into pose_q; geometry and pose SHALL NOT change at any other time (no mid-frame tearing).
REQ-019 Anim counter SHALL increment on each i_frame_start when i_anim_en=1 and the newly latched pose is RUN; at ANIM_DIV-1 it SHALL wrap to 0 and toggle run phase.
REQ-020 When the pose latched on i_frame_start is not RUN, anim counter and run phase SHALL clear to 0 on that cycle.
REQ-021 i_anim_en=0 SHALL freeze counter and phase at their current values.
REQ-022 Bitmap select: RUN -> RUN0/RUN1 by phase; JUMP, DUCK, DEAD -> own bitmap.
REQ-023 Box test SHALL use widths HPOS_W+1 and VPOS_W+1: inside iff X_POS <= i_hpos < X_POS+SPR_W and vpos_q <= i_vpos < vpos_q+SPR_H; no modular wrap, rows beyond 2^VPOS_W-1 are clipped.
REQ-024 Inside the box, ROM row = i_vpos-vpos_q, column = i_hpos-X_POS; outside, the ROM SHALL NOT be indexed out of range and pixel SHALL be 0.
REQ-025 o_color and o_in_box SHALL be registered with exactly 1 cycle latency relative to i_hpos/i_vpos.
REQ-026 If i_frame_start coincides with an in-box beam position, that cycle SHALL use the pre-latch vpos_q/pose_q/phase; new values take effect the next cycle.

Reset
REQ-027 While rst_n=0: o_color=0, o_in_box=0, vpos_q=0, pose_q=RUN, anim counter=0, phase=0, asynchronously.
REQ-028 Release of rst_n SHALL be synchronous to clk; first valid output follows the first clocked pixel input.
REQ-029 Reset asserted mid-frame SHALL force outputs to 0 immediately; state resumes from reset values after release.

Verification
REQ-030 Reset: drive in-box coordinates, pulse rst_n low mid-line -> o_color=0, o_in_box=0 same cycle; after release with vpos_q=0, hpos=X_POS, vpos=0 -> o_in_box=1 one cycle later.
REQ-031 Latch: i_sprite_vpos=100, frame_start; then i_sprite_vpos=50 mid-frame -> box stays rows 100..115 until next frame_start.
REQ-032 Animation: pose RUN, anim_en=1, ANIM_DIV=6 -> phase toggles on 6th, 12th frame_start; set pose JUMP -> counter and phase 0, JUMP bitmap shown.
REQ-033 Scan: full-frame raster per pose vs reference bitmap model, 1-cycle-delayed compare -> zero mismatches; o_color=0 everywhere outside box.
REQ-034 Clip: i_sprite_vpos=2^VPOS_W-4 -> only 4 rows drawn, no sprite rows at i_vpos 0..SPR_H-5.
REQ-035 Boundaries: i_hpos=X_POS-1 and X_POS+SPR_W -> o_in_box=0; X_POS and X_POS+SPR_W-1 -> o_in_box=1.
